// File: rtl/exotiny_qspi_ctrl.sv
// exotiny_qspi_ctrl: QSPI memory controller for the ExoTiny core bus.
// Turns single-word bus requests into QSPI transactions.
// ROM is the SPI flash (read 0xEB); RAM is the QSPI PSRAM (read 0xEB, write 0x38).
// After a request is accepted, one setup cycle passes before the chip select goes low.
// Each SCK period then takes two clk cycles: phase 0 drives, phase 1 samples.
module exotiny_qspi_ctrl #(
  parameter int ROM_DUMMY = 4,
  parameter int RAM_DUMMY = 6
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [24:0] adr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] dat_i,
  output logic        rdy_o,
  output logic [31:0] dat_o,
  output logic        mem_cs_rom_on,
  output logic        mem_cs_ram_on,
  output logic        mem_sck_o,
  input  logic [3:0]  mem_sd_i,
  output logic [3:0]  mem_sd_o,
  output logic [3:0]  mem_sd_oen_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_READ    = 8'hEB;
  localparam logic [7:0] CMD_WRITE   = 8'h38;
  localparam logic [7:0] ROM_DUMMY_L = 8'(ROM_DUMMY);
  localparam logic [7:0] RAM_DUMMY_L = 8'(RAM_DUMMY);

  state_t      state_q, state_d, next_state;
  logic        ph_q, ph_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  len_cur;
  logic        we_q, we_d;
  logic        ram_q, ram_d;
  logic        nop_q, nop_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] dat_q, dat_d;
  logic        rdy_q, rdy_d;
  logic        cs_rom_q, cs_rom_d;
  logic        cs_ram_q, cs_ram_d;
  logic        sck_q, sck_d;
  logic [3:0]  sd_o_q, sd_o_d;
  logic [3:0]  oen_q, oen_d;

  logic [4:0]  rd_pos;
  logic [4:0]  wr_pos;
  logic [1:0]  be_low;
  logic [2:0]  be_cnt;
  logic        active;
  logic [7:0]  cmd_sh;
  logic [23:0] addr_sh;
  logic [1:0]  unused_adr;

  // The two low address bits never reach the bus: reads are word aligned and
  // writes take their byte offset from be_i.
  assign unused_adr = adr_i[1:0];

  // Lowest enabled byte lane and number of enabled lanes of the incoming request.
  always_comb begin
    be_low = 2'd0;
    be_cnt = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (be_i[i]) be_low = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      be_cnt = be_cnt + {2'b00, be_i[i]};
    end
  end

  // Length in SCK periods of the current state and the state that follows it.
  always_comb begin
    len_cur    = 8'd0;
    next_state = ST_IDLE;
    case (state_q)
      ST_CMD: begin
        len_cur    = 8'd8;
        next_state = ST_ADDR;
      end
      ST_ADDR: begin
        len_cur = 8'd6;
        if (we_q)                    next_state = ST_DATA;
        else if (!ram_q)             next_state = ST_MODE;
        else if (RAM_DUMMY_L != 8'd0) next_state = ST_DUMMY;
        else                         next_state = ST_DATA;
      end
      ST_MODE: begin
        len_cur    = 8'd2;
        next_state = (ROM_DUMMY_L != 8'd0) ? ST_DUMMY : ST_DATA;
      end
      ST_DUMMY: begin
        len_cur    = ram_q ? RAM_DUMMY_L : ROM_DUMMY_L;
        next_state = ST_DATA;
      end
      ST_DATA: begin
        len_cur    = we_q ? wlen_q : 8'd8;
        next_state = ST_DONE;
      end
      default: begin
        len_cur    = 8'd0;
        next_state = ST_IDLE;
      end
    endcase
  end

  // Sequencer: latches the request, walks the phases and collects read nibbles.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ram_d   = ram_q;
    nop_d   = nop_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wlen_d  = wlen_q;
    rdat_d  = rdat_q;
    dat_d   = dat_q;
    rd_pos  = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          ram_d   = adr_i[24];
          nop_d   = we_i & (~adr_i[24] | (be_i == 4'd0));
          addr_d  = we_i ? {adr_i[23:2], be_low} : {adr_i[23:2], 2'b00};
          wdat_d  = dat_i >> {be_low, 3'b000};
          wlen_d  = {4'd0, be_cnt, 1'b0};
          state_d = ST_START;
          ph_d    = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      ST_START: begin
        state_d = nop_q ? ST_DONE : ST_CMD;
        ph_d    = 1'b0;
        cnt_d   = 8'd0;
      end
      ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (state_q == ST_DATA && !we_q) begin
            rdat_d[rd_pos +: 4] = mem_sd_i;
          end
          if (cnt_q == len_cur - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = next_state;
            if (state_q == ST_DATA && !we_q) dat_d = rdat_d;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the upcoming cycle, decoded from the next state.
  always_comb begin
    active   = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_MODE) ||
               (state_d == ST_DUMMY) || (state_d == ST_DATA);
    cs_rom_d = ~(active & ~ram_q);
    cs_ram_d = ~(active & ram_q);
    sck_d    = active & ph_d;
    rdy_d    = (state_d == ST_DONE);
    cmd_sh   = (we_q ? CMD_WRITE : CMD_READ) << cnt_d[2:0];
    addr_sh  = addr_q << {cnt_d[2:0], 2'b00};
    wr_pos   = {cnt_d[2:1], ~cnt_d[0], 2'b00};
    sd_o_d   = 4'h0;
    oen_d    = 4'h0;
    case (state_d)
      ST_CMD: begin
        sd_o_d = {3'b000, cmd_sh[7]};
        oen_d  = 4'b0001;
      end
      ST_ADDR: begin
        sd_o_d = addr_sh[23:20];
        oen_d  = 4'b1111;
      end
      ST_MODE: begin
        sd_o_d = 4'h0;
        oen_d  = 4'b1111;
      end
      ST_DATA: begin
        if (we_q) begin
          sd_o_d = wdat_q[wr_pos +: 4];
          oen_d  = 4'b1111;
        end
      end
      default: begin
        sd_o_d = 4'h0;
        oen_d  = 4'h0;
      end
    endcase
  end

  // All state and pins are registered; reset returns everything to idle at once.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      ph_q     <= 1'b0;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      ram_q    <= 1'b0;
      nop_q    <= 1'b0;
      addr_q   <= 24'd0;
      wdat_q   <= 32'd0;
      wlen_q   <= 8'd0;
      rdat_q   <= 32'd0;
      dat_q    <= 32'd0;
      rdy_q    <= 1'b0;
      cs_rom_q <= 1'b1;
      cs_ram_q <= 1'b1;
      sck_q    <= 1'b0;
      sd_o_q   <= 4'h0;
      oen_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      ram_q    <= ram_d;
      nop_q    <= nop_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      wlen_q   <= wlen_d;
      rdat_q   <= rdat_d;
      dat_q    <= dat_d;
      rdy_q    <= rdy_d;
      cs_rom_q <= cs_rom_d;
      cs_ram_q <= cs_ram_d;
      sck_q    <= sck_d;
      sd_o_q   <= sd_o_d;
      oen_q    <= oen_d;
    end
  end

  assign rdy_o         = rdy_q;
  assign dat_o         = dat_q;
  assign mem_cs_rom_on = cs_rom_q;
  assign mem_cs_ram_on = cs_ram_q;
  assign mem_sck_o     = sck_q;
  assign mem_sd_o      = sd_o_q;
  assign mem_sd_oen_o  = oen_q;

endmodule

// File: tb/tb_exotiny_qspi_ctrl.sv
// tb_exotiny_qspi_ctrl: drives bus requests into exotiny_qspi_ctrl, plays the
// flash and PSRAM on the QSPI pins, and compares against a word-level model.
module tb_exotiny_qspi_ctrl;

  localparam int ROM_DUMMY = 4;
  localparam int RAM_DUMMY = 6;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        req_i;
  logic        we_i;
  logic [24:0] adr_i;
  logic [3:0]  be_i;
  logic [31:0] dat_i;
  logic        rdy_o;
  logic [31:0] dat_o;
  logic        mem_cs_rom_on;
  logic        mem_cs_ram_on;
  logic        mem_sck_o;
  logic [3:0]  mem_sd_i = 4'h0;
  logic [3:0]  mem_sd_o;
  logic [3:0]  mem_sd_oen_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected read word and expected PSRAM contents.
  logic [31:0] expDat = 32'd0;
  logic [7:0]  refRam [int];

  // Device-side capture of the most recent QSPI transaction.
  logic [7:0]  devRam [int];
  logic        prevSck = 1'b0;
  logic        prevCsLow = 1'b0;
  int          gapCnt = 1000;
  int          lastGap = 1000;
  int          periods = 0;
  int          txCount = 0;
  int          protoErr = 0;
  int          idleErr = 0;
  logic [7:0]  capCmd = 8'h00;
  logic [23:0] capAddr = 24'h0;
  logic        capDev = 1'b0;
  logic [3:0]  wrHi = 4'h0;
  logic [7:0]  capWr [$];

  exotiny_qspi_ctrl #(
    .ROM_DUMMY(ROM_DUMMY),
    .RAM_DUMMY(RAM_DUMMY)
  ) dut (
    .clk_i        (clk),
    .rst_in       (rst_in),
    .req_i        (req_i),
    .we_i         (we_i),
    .adr_i        (adr_i),
    .be_i         (be_i),
    .dat_i        (dat_i),
    .rdy_o        (rdy_o),
    .dat_o        (dat_o),
    .mem_cs_rom_on(mem_cs_rom_on),
    .mem_cs_ram_on(mem_cs_ram_on),
    .mem_sck_o    (mem_sck_o),
    .mem_sd_i     (mem_sd_i),
    .mem_sd_o     (mem_sd_o),
    .mem_sd_oen_o (mem_sd_oen_o)
  );

  always #5 clk = ~clk;

  // Flash contents: a simple address-derived pattern.
  function automatic logic [7:0] romByte(input logic [23:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  function automatic logic [7:0] devRamByte(input logic [23:0] a);
    return devRam.exists(int'(a)) ? devRam[int'(a)] : 8'h00;
  endfunction

  function automatic logic [7:0] refRamByte(input logic [23:0] a);
    return refRam.exists(int'(a)) ? refRam[int'(a)] : 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory devices: sample the pins mid-cycle, decode each SCK period by its
  // position in the transaction and answer reads with the next nibble.
  always @(negedge clk) begin
    logic       csLow;
    logic [7:0] b;
    int         p;
    int         ds;
    int         j;
    csLow = !mem_cs_rom_on || !mem_cs_ram_on;
    if (!mem_cs_rom_on && !mem_cs_ram_on) protoErr++;
    if (!csLow) begin
      gapCnt++;
      if (mem_sck_o || mem_sd_oen_o != 4'h0) idleErr++;
    end
    if (csLow && !prevCsLow) begin
      lastGap = gapCnt;
      gapCnt  = 0;
      periods = 0;
      capCmd  = 8'h00;
      capAddr = 24'h0;
      capDev  = !mem_cs_ram_on;
      capWr.delete();
      txCount++;
    end
    if (csLow && mem_sck_o && !prevSck) begin
      p = periods;
      periods++;
      if (p < 8) begin
        capCmd = {capCmd[6:0], mem_sd_o[0]};
        if (mem_sd_oen_o != 4'b0001) protoErr++;
      end else if (p < 14) begin
        capAddr = {capAddr[19:0], mem_sd_o};
        if (mem_sd_oen_o != 4'b1111) protoErr++;
      end else if (capCmd == 8'h38) begin
        if (mem_sd_oen_o != 4'b1111) protoErr++;
        j = p - 14;
        if (j % 2 == 0) begin
          wrHi = mem_sd_o;
        end else begin
          b = {wrHi, mem_sd_o};
          capWr.push_back(b);
          devRam[int'(capAddr) + j / 2] = b;
        end
      end else begin
        ds = capDev ? 14 + RAM_DUMMY : 16 + ROM_DUMMY;
        if (!capDev && p < 16) begin
          if (mem_sd_o != 4'h0 || mem_sd_oen_o != 4'b1111) protoErr++;
        end else begin
          if (mem_sd_oen_o != 4'h0) protoErr++;
          if (p >= ds) begin
            j = p - ds;
            b = capDev ? devRamByte(24'(int'(capAddr) + j / 2)) : romByte(24'(int'(capAddr) + j / 2));
            mem_sd_i = (j % 2 == 0) ? b[7:4] : b[3:0];
          end
        end
      end
    end
    prevSck   = mem_sck_o;
    prevCsLow = csLow;
  end

  // One bus transfer: predict the outcome from the request alone, run it, compare.
  // btb: called right after the previous rdy_o with req_i still high.
  // keep: leave req_i high afterwards so the next call can be back-to-back.
  task automatic applyStimulus(input logic we, input logic [24:0] adr, input logic [3:0] be,
                               input logic [31:0] dat, input bit btb, input bit keep);
    bit          nop;
    int          n;
    int          lat;
    int          txBefore;
    int          pop;
    int          lo;
    logic [23:0] base;
    logic [31:0] rd;
    logic [7:0]  wb [$];
    pop = 0;
    lo  = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    for (int i = 0; i < 4; i++) if (be[i]) pop++;
    nop  = we && (!adr[24] || be == 4'd0);
    base = {adr[23:2], 2'b00};
    if (nop)          n = 0;
    else if (we)      n = 8 + 6 + 2 * pop;
    else if (adr[24]) n = 8 + 6 + RAM_DUMMY + 8;
    else              n = 8 + 6 + 2 + ROM_DUMMY + 8;
    for (int k = 0; k < 4; k++) begin
      rd[8*k +: 8] = adr[24] ? refRamByte(base + 24'(k)) : romByte(base + 24'(k));
    end
    if (!nop && we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          refRam[int'(base) + l] = dat[8*l +: 8];
          wb.push_back(dat[8*l +: 8]);
        end
      end
    end
    txBefore = txCount;
    if (!btb) @(negedge clk);
    req_i = 1'b1;
    we_i  = we;
    adr_i = adr;
    be_i  = be;
    dat_i = dat;
    if (btb) begin
      @(posedge clk);
      #1;
      checkOutput("rdy_pulse", 32'(rdy_o), 32'd0);
    end
    @(posedge clk);
    #1;
    we_i  = 1'($urandom);
    adr_i = 25'($urandom);
    be_i  = 4'($urandom);
    dat_i = $urandom;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      if (rdy_o) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(2 * n + 1));
    if (!we) expDat = rd;
    checkOutput("dat_o", dat_o, expDat);
    if (nop) begin
      checkOutput("no_cs_activity", 32'(txCount), 32'(txBefore));
    end else begin
      checkOutput("cs_asserted", 32'(txCount), 32'(txBefore + 1));
      checkOutput("cmd", 32'(capCmd), we ? 32'h38 : 32'hEB);
      checkOutput("addr", 32'(capAddr), we ? 32'({adr[23:2], 2'(lo)}) : 32'(base));
      checkOutput("device", 32'(capDev), 32'(adr[24]));
      checkOutput("sck_periods", 32'(periods), 32'(n));
      if (we) begin
        checkOutput("wr_count", 32'(capWr.size()), 32'(pop));
        for (int i = 0; i < wb.size() && i < capWr.size(); i++) begin
          checkOutput("wr_byte", 32'(capWr[i]), 32'(wb[i]));
        end
      end
      if (btb) checkOutput("cs_gap_ok", 32'(lastGap >= 2), 32'd1);
    end
    checkOutput("proto_err", 32'(protoErr), 32'd0);
    checkOutput("idle_err", 32'(idleErr), 32'd0);
    if (!keep) begin
      req_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rdy_pulse", 32'(rdy_o), 32'd0);
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  beTab [0:10];
    logic        we;
    logic [24:0] adr;
    bit          keep;
    bit          prevKeep;
    beTab[0] = 4'b0001; beTab[1] = 4'b0010; beTab[2]  = 4'b0100; beTab[3] = 4'b1000;
    beTab[4] = 4'b0011; beTab[5] = 4'b0110; beTab[6]  = 4'b1100; beTab[7] = 4'b0111;
    beTab[8] = 4'b1110; beTab[9] = 4'b1111; beTab[10] = 4'b0000;

    rst_in = 1'b0;
    req_i  = 1'b0;
    we_i   = 1'b0;
    adr_i  = 25'd0;
    be_i   = 4'd0;
    dat_i  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_rom", 32'(mem_cs_rom_on), 32'd1);
    checkOutput("rst_cs_ram", 32'(mem_cs_ram_on), 32'd1);
    checkOutput("rst_sck", 32'(mem_sck_o), 32'd0);
    checkOutput("rst_sd_o", 32'(mem_sd_o), 32'd0);
    checkOutput("rst_oen", 32'(mem_sd_oen_o), 32'd0);
    checkOutput("rst_rdy", 32'(rdy_o), 32'd0);
    checkOutput("rst_dat", dat_o, 32'd0);
    @(negedge clk);
    rst_in = 1'b1;

    $display("[TB] directed transfers");
    applyStimulus(1'b0, 25'h0000100, 4'b0000, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 25'h1000002, 4'b0100, 32'h00AB0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 25'h1000000, 4'b0000, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 25'h0000010, 4'b1111, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(1'b1, 25'h1000004, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(1'b1, 25'h1000008, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
    applyStimulus(1'b0, 25'h1000008, 4'b0000, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 25'h0123456, 4'b0000, 32'h0, 1'b1, 1'b0);

    $display("[TB] random transfers");
    prevKeep = 1'b0;
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom);
      adr  = ($urandom_range(0, 9) < 7) ? {1'b1, 24'($urandom_range(0, 63))} : {1'b0, 24'($urandom)};
      keep = (t != 39) && ($urandom_range(0, 3) == 0);
      applyStimulus(we, adr, beTab[$urandom_range(0, 10)], $urandom, prevKeep, keep);
      prevKeep = keep;
    end

    $display("[TB] reset during RAM read address phase");
    @(negedge clk);
    req_i = 1'b1;
    we_i  = 1'b0;
    adr_i = 25'h1000040;
    be_i  = 4'd0;
    @(posedge clk);
    repeat (21) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_cs_ram_low", 32'(mem_cs_ram_on), 32'd0);
    rst_in = 1'b0;
    req_i  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_cs_ram", 32'(mem_cs_ram_on), 32'd1);
    checkOutput("mid_rst_cs_rom", 32'(mem_cs_rom_on), 32'd1);
    checkOutput("mid_rst_oen", 32'(mem_sd_oen_o), 32'd0);
    checkOutput("mid_rst_rdy", 32'(rdy_o), 32'd0);
    checkOutput("mid_rst_dat", dat_o, 32'd0);
    expDat = 32'd0;
    @(negedge clk);
    rst_in = 1'b1;
    applyStimulus(1'b0, 25'h0000100, 4'b0000, 32'h0, 1'b0, 1'b0);
    checkOutput("rom_word_after_reset", dat_o, 32'h03020100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
